// File: rtl/reg_bus_master_if.sv
// Register-bus master interface bundle.
// Groups the command handshake, response handshake and register-bus signals of reg_bus_master.
//   cmd_*   : command channel (valid/ready), op/addr/data/mask payload
//   rsp_*   : response channel (valid/ready), data + timeout error
//   acc_en_o/wr_en_o/addr_o/wdata_o/rdata_i : 3-bit-address / 16-bit-data register bus
// Modports:
//   master : view of the bus initiator (reg_bus_master itself)
//   slave  : view of the environment (host sequencer + bus responder)
interface reg_bus_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [2:0]  cmd_addr_i;
    logic [15:0] cmd_data_i;
    logic [15:0] cmd_mask_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [15:0] rsp_data_o;
    logic        rsp_err_o;
    logic        acc_en_o;
    logic        wr_en_o;
    logic [2:0]  addr_o;
    logic [15:0] wdata_o;
    logic [15:0] rdata_i;

    modport master (
        input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i,
        input  rsp_ready_i, rdata_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        output acc_en_o, wr_en_o, addr_o, wdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i,
        output rsp_ready_i, rdata_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        input  acc_en_o, wr_en_o, addr_o, wdata_o
    );
endinterface

// File: rtl/reg_bus_master.sv
// Register-bus initiator.
// Accepts one command at a time (WRITE, READ, read-modify-write, masked POLL with timeout),
// issues single-cycle register-bus accesses and returns exactly one response per command.
// Ports:
//   clk_i   : clock, rising edge
//   rstn_i  : asynchronous active-low reset
//   bus     : reg_bus_master_if.master (command, response and register-bus signals)
// All outputs are registered except cmd_ready_o, which is high in IDLE only.
module reg_bus_master #(
    parameter int unsigned POLL_MAX = 16,
    parameter int unsigned POLL_GAP = 3
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    reg_bus_master_if.master  bus
);

    localparam int unsigned CntW = $clog2(POLL_MAX + 1);
    localparam int unsigned GapW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    localparam logic [1:0] OpWrite = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpRmw   = 2'b10;
    localparam logic [1:0] OpPoll  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRmwRd,
        StRmwWr,
        StPollRd,
        StPollGap,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      addr_q, addr_d;
    logic [15:0]     data_q, data_d;
    logic [15:0]     mask_q, mask_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [GapW-1:0] gap_q, gap_d;

    logic            acc_en_q, acc_en_d;
    logic            wr_en_q, wr_en_d;
    logic [2:0]      bus_addr_q, bus_addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    logic [15:0]     rmw_val;
    logic            poll_match;
    logic [CntW-1:0] cnt_inc;

    assign rmw_val    = (bus.rdata_i & ~mask_q) | (data_q & mask_q);
    assign poll_match = ((bus.rdata_i ^ data_q) & mask_q) == 16'h0000;
    assign cnt_inc    = cnt_q + CntW'(1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        // Bus signals are single-cycle pulses: idle (all zero) unless a transition drives them.
        acc_en_d    = 1'b0;
        wr_en_d     = 1'b0;
        bus_addr_d  = 3'd0;
        wdata_d     = 16'h0000;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid_i) begin
                    addr_d     = bus.cmd_addr_i;
                    data_d     = bus.cmd_data_i;
                    mask_d     = bus.cmd_mask_i;
                    cnt_d      = '0;
                    gap_d      = '0;
                    acc_en_d   = 1'b1;
                    bus_addr_d = bus.cmd_addr_i;
                    unique case (bus.cmd_op_i)
                        OpWrite: begin
                            wr_en_d = 1'b1;
                            wdata_d = bus.cmd_data_i;
                            state_d = StWr;
                        end
                        OpRead:  state_d = StRd;
                        OpRmw:   state_d = StRmwRd;
                        OpPoll:  state_d = StPollRd;
                        default: state_d = StIdle;
                    endcase
                end
            end
            StWr: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = data_q;
                rsp_err_d   = 1'b0;
                state_d     = StResp;
            end
            StRd: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus.rdata_i;
                rsp_err_d   = 1'b0;
                state_d     = StResp;
            end
            StRmwRd: begin
                acc_en_d   = 1'b1;
                wr_en_d    = 1'b1;
                bus_addr_d = addr_q;
                wdata_d    = rmw_val;
                state_d    = StRmwWr;
            end
            StRmwWr: begin
                // wdata_q still holds the value being written this cycle.
                rsp_valid_d = 1'b1;
                rsp_data_d  = wdata_q;
                rsp_err_d   = 1'b0;
                state_d     = StResp;
            end
            StPollRd: begin
                cnt_d = cnt_inc;
                if (poll_match) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.rdata_i;
                    rsp_err_d   = 1'b0;
                    state_d     = StResp;
                end else if (32'(cnt_inc) >= POLL_MAX) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.rdata_i;
                    rsp_err_d   = 1'b1;
                    state_d     = StResp;
                end else if (POLL_GAP == 0) begin
                    acc_en_d   = 1'b1;
                    bus_addr_d = addr_q;
                    state_d    = StPollRd;
                end else begin
                    gap_d   = '0;
                    state_d = StPollGap;
                end
            end
            StPollGap: begin
                if (32'(gap_q) + 32'd1 >= POLL_GAP) begin
                    gap_d      = '0;
                    acc_en_d   = 1'b1;
                    bus_addr_d = addr_q;
                    state_d    = StPollRd;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            StResp: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= StIdle;
            addr_q      <= 3'd0;
            data_q      <= 16'h0000;
            mask_q      <= 16'h0000;
            cnt_q       <= '0;
            gap_q       <= '0;
            acc_en_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            bus_addr_q  <= 3'd0;
            wdata_q     <= 16'h0000;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            acc_en_q    <= acc_en_d;
            wr_en_q     <= wr_en_d;
            bus_addr_q  <= bus_addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready_o = (state_q == StIdle);
    assign bus.acc_en_o    = acc_en_q;
    assign bus.wr_en_o     = wr_en_q;
    assign bus.addr_o      = bus_addr_q;
    assign bus.wdata_o     = wdata_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master: directed commands, expected bus accesses and
// responses queued at issue time, independent monitors compare what the DUT presents.
module tb_reg_bus_master;

    localparam int unsigned PollMax = 16;
    localparam int unsigned PollGap = 3;
    localparam int Step = int'(PollGap) + 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    reg_bus_master_if bus ();

    reg_bus_master #(
        .POLL_MAX (PollMax),
        .POLL_GAP (PollGap)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Cycle counter: value k is visible during the cycle following the k-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder: scripted read data (rd_a for the first rd_sw reads of a command, then rd_b).
    int          rd_total = 0;
    int          rd_base  = 0;
    int          rd_sw    = 0;
    logic [15:0] rd_a = 16'h0000;
    logic [15:0] rd_b = 16'h0000;
    always @(posedge clk) if (bus.acc_en_o && !bus.wr_en_o) rd_total <= rd_total + 1;
    assign bus.rdata_i = (bus.acc_en_o && !bus.wr_en_o) ?
                         (((rd_total - rd_base) < rd_sw) ? rd_a : rd_b) : 16'hDEAD;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } bus_exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        err;
    } rsp_exp_t;

    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];

    task automatic exp_acc(input int c, input logic wr, input logic [2:0] addr,
                           input logic [15:0] wd);
        bus_exp_t e;
        e.cyc = c; e.wr = wr; e.addr = addr; e.wdata = wd;
        bus_q.push_back(e);
    endtask

    task automatic exp_rsp(input int c, input logic [15:0] data, input logic err);
        rsp_exp_t e;
        e.cyc = c; e.data = data; e.err = err;
        rsp_q.push_back(e);
    endtask

    // Bus monitor: every access must match the next expected one; idle bus must be all zero.
    always @(negedge clk) begin
        bus_exp_t e;
        if (bus.acc_en_o) begin
            if (bus_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_access: got addr=%0d wr=%0b at cyc %0d, required none",
                         bus.addr_o, bus.wr_en_o, cyc);
            end else begin
                e = bus_q.pop_front();
                chk("acc_cycle", 32'(cyc), 32'(e.cyc));
                chk("acc_wr", 32'(bus.wr_en_o), 32'(e.wr));
                chk("acc_addr", 32'(bus.addr_o), 32'(e.addr));
                chk("acc_wdata", 32'(bus.wdata_o), 32'(e.wdata));
            end
        end else begin
            chk("idle_bus", 32'({bus.wr_en_o, bus.addr_o, bus.wdata_o}), 32'd0);
        end
    end

    // Response monitor: first valid cycle compared to the scoreboard, then held stable.
    logic        vld_prev = 1'b0;
    logic [15:0] cap_data = 16'h0000;
    logic        cap_err  = 1'b0;
    always @(negedge clk) begin
        rsp_exp_t e;
        if (bus.rsp_valid_o) begin
            if (!vld_prev) begin
                if (rsp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_rsp: got data=0x%0h err=%0b, required none",
                             bus.rsp_data_o, bus.rsp_err_o);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rsp_data", 32'(bus.rsp_data_o), 32'(e.data));
                    chk("rsp_err", 32'(bus.rsp_err_o), 32'(e.err));
                end
                cap_data = bus.rsp_data_o;
                cap_err  = bus.rsp_err_o;
            end else begin
                chk("rsp_stable", 32'({bus.rsp_err_o, bus.rsp_data_o}), 32'({cap_err, cap_data}));
            end
            chk("cmd_ready_in_resp", 32'(bus.cmd_ready_o), 32'd0);
        end
        vld_prev = bus.rsp_valid_o;
    end

    // Issue one command; a = cycle in which the first access is expected.
    task automatic send(input logic [1:0] op, input logic [2:0] addr, input logic [15:0] data,
                        input logic [15:0] mask, input logic [15:0] ra, input logic [15:0] rb,
                        input int rsw, output int a);
        int n = 0;
        a = -1;
        @(negedge clk);
        while (!bus.cmd_ready_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready_o) begin
            n_chk++;
            $display("FAIL send_wait: got cmd_ready=0, required 1 within 500 cycles");
            return;
        end
        rd_a    = ra;
        rd_b    = rb;
        rd_sw   = rsw;
        rd_base = rd_total;
        bus.cmd_op_i    = op;
        bus.cmd_addr_i  = addr;
        bus.cmd_data_i  = data;
        bus.cmd_mask_i  = mask;
        bus.cmd_valid_i = 1'b1;
        a = cyc + 1;
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = 2'b00;
        bus.cmd_addr_i  = 3'd0;
        bus.cmd_data_i  = 16'h0000;
        bus.cmd_mask_i  = 16'h0000;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_acc_en"}, 32'(bus.acc_en_o), 32'd0);
        chk({tag, "_wr_en"}, 32'(bus.wr_en_o), 32'd0);
        chk({tag, "_addr"}, 32'(bus.addr_o), 32'd0);
        chk({tag, "_wdata"}, 32'(bus.wdata_o), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        chk({tag, "_rsp_data"}, 32'(bus.rsp_data_o), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err_o), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready_o), 32'd1);
    endtask

    initial begin
        int a;
        int n;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = 2'b00;
        bus.cmd_addr_i  = 3'd0;
        bus.cmd_data_i  = 16'h0000;
        bus.cmd_mask_i  = 16'h0000;
        bus.rsp_ready_i = 1'b1;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;

        // WRITE addr 1
        send(2'b00, 3'd1, 16'h3200, 16'hFFFF, 16'h0, 16'h0, 0, a);
        exp_acc(a, 1'b1, 3'd1, 16'h3200);
        exp_rsp(a + 1, 16'h3200, 1'b0);

        // READ addr 4
        send(2'b01, 3'd4, 16'hBEEF, 16'h0000, 16'h0155, 16'h0155, 1, a);
        exp_acc(a, 1'b0, 3'd4, 16'h0000);
        exp_rsp(a + 1, 16'h0155, 1'b0);

        // RMW addr 2: (0x3135 & ~0x0030) | (0x0020 & 0x0030) = 0x3125
        send(2'b10, 3'd2, 16'h0020, 16'h0030, 16'h3135, 16'h3135, 1, a);
        exp_acc(a, 1'b0, 3'd2, 16'h0000);
        exp_acc(a + 1, 1'b1, 3'd2, 16'h3125);
        exp_rsp(a + 2, 16'h3125, 1'b0);

        // RMW addr 7: (0x1234 & 0x00FF) | (0xAB00 & 0xFF00) = 0xAB34
        send(2'b10, 3'd7, 16'hAB00, 16'hFF00, 16'h1234, 16'h1234, 1, a);
        exp_acc(a, 1'b0, 3'd7, 16'h0000);
        exp_acc(a + 1, 1'b1, 3'd7, 16'hAB34);
        exp_rsp(a + 2, 16'hAB34, 1'b0);

        // POLL addr 6: bit 12 set for 3 reads, clear on the 4th
        send(2'b11, 3'd6, 16'h0000, 16'h1000, 16'h1000, 16'h0000, 3, a);
        for (int k = 0; k < 4; k++) exp_acc(a + k * Step, 1'b0, 3'd6, 16'h0000);
        exp_rsp(a + 3 * Step + 1, 16'h0000, 1'b0);

        // POLL with mask 0 matches on the first read
        send(2'b11, 3'd3, 16'h1234, 16'h0000, 16'hABCD, 16'hABCD, 1, a);
        exp_acc(a, 1'b0, 3'd3, 16'h0000);
        exp_rsp(a + 1, 16'hABCD, 1'b0);

        // POLL never matching: 16 reads, timeout with last read data
        send(2'b11, 3'd5, 16'h0055, 16'h00FF, 16'h1200, 16'h12AA, 15, a);
        for (int k = 0; k < int'(PollMax); k++) exp_acc(a + k * Step, 1'b0, 3'd5, 16'h0000);
        exp_rsp(a + (int'(PollMax) - 1) * Step + 1, 16'h12AA, 1'b1);

        // READ after timeout
        send(2'b01, 3'd0, 16'h0000, 16'h0000, 16'h8001, 16'h8001, 1, a);
        exp_acc(a, 1'b0, 3'd0, 16'h0000);
        exp_rsp(a + 1, 16'h8001, 1'b0);

        // READ with response back-pressure
        send(2'b01, 3'd2, 16'h0000, 16'h0000, 16'h7E81, 16'h7E81, 1, a);
        bus.rsp_ready_i = 1'b0;
        exp_acc(a, 1'b0, 3'd2, 16'h0000);
        exp_rsp(a + 1, 16'h7E81, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid_o && n < 20);
        repeat (5) @(negedge clk);
        chk("held_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("rsp_drop", 32'(bus.rsp_valid_o), 32'd0);
        chk("cmd_ready_after_rsp", 32'(bus.cmd_ready_o), 32'd1);

        // Reset between RMW read and write: the write must never appear
        send(2'b10, 3'd1, 16'h00F0, 16'h00F0, 16'h0F0F, 16'h0F0F, 1, a);
        exp_acc(a, 1'b0, 3'd1, 16'h0000);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("cmd_ready_after_release", 32'(bus.cmd_ready_o), 32'd1);
        repeat (4) @(negedge clk);

        // READ after the abort works normally
        send(2'b01, 3'd7, 16'h0000, 16'h0000, 16'h5A5A, 16'h5A5A, 1, a);
        exp_acc(a, 1'b0, 3'd7, 16'h0000);
        exp_rsp(a + 1, 16'h5A5A, 1'b0);

        n = 0;
        while ((bus_q.size() != 0 || rsp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
Initiator for the on-chip 3-bit-address / 16-bit-data register bus (acc_en / wr_en / addr / wdata / rdata). It accepts one command at a time from a controller over a valid/ready handshake and supports four operations: WRITE, READ, read-modify-write (RMW) and masked POLL-until-match with timeout. It issues single-cycle bus accesses and returns exactly one response per command over a valid/ready handshake. It sits between the host sequencer and the counter/timer register block, and the bus responder returns read data combinationally in the access cycle.

Parameters:
POLL_MAX, 16, maximum poll reads before timeout (>=1)
POLL_GAP, 3, idle cycles between consecutive poll reads (>=0)

Ports:
clk_i  in  1  clock, all logic on rising edge
rstn_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_op_i  in  2  00 WRITE, 01 READ, 10 RMW, 11 POLL
cmd_addr_i  in  3  register address
cmd_data_i  in  16  write data / RMW set value / poll compare value
cmd_mask_i  in  16  RMW / POLL bit mask (ignored for WRITE/READ)
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_data_o  out  16  result data
rsp_err_o  out  1  1 = poll timeout
acc_en_o  out  1  bus access enable
wr_en_o  out  1  bus write enable
addr_o  out  3  bus address
wdata_o  out  16  bus write data
rdata_i  in  16  bus read data, valid in access cycle when wr_en_o=0

Behaviour:
- Clocking and reset: one clock, clk_i; reset is asynchronous and active-low on rstn_i.
- Reset values: state IDLE; acc_en_o, wr_en_o, addr_o, wdata_o, rsp_valid_o, rsp_data_o and rsp_err_o all 0; cmd_ready_o = 1.
- All outputs are registered except cmd_ready_o = (state==IDLE).
- States: IDLE, WR, RD, RMW_RD, RMW_WR, POLL_RD, POLL_GAP, RESP.
- Bus rules:
  - acc_en_o is high for exactly one cycle per access.
  - wr_en_o is high only with acc_en_o.
  - addr_o and wdata_o are 0 whenever acc_en_o=0.
  - rdata_i is sampled on the clock edge that ends a read access cycle.
- Acceptance: on cycle T (valid&ready), op/addr/data/mask are latched, and the first access drives in cycle T+1.
- WRITE: access with wr_en=1, wdata=cmd_data in T+1. Response in T+2 with rsp_data=cmd_data, err=0.
- READ: access with wr_en=0 in T+1. Response in T+2 with rsp_data=sampled rdata_i, err=0.
- RMW:
  - Read in T+1, sampling value R.
  - Write in T+2 with wdata = (R & ~mask) | (cmd_data & mask), driven to the same address.
  - Response in T+3 with rsp_data = written value, err=0.
- POLL:
  - A read is issued in POLL_RD, followed by a one-cycle access count increment.
  - Match when (rdata_i & mask) == (cmd_data & mask). On match, respond next cycle with data=rdata_i, err=0.
  - On no match with count < POLL_MAX, go to POLL_GAP for POLL_GAP idle cycles, then to POLL_RD. When POLL_GAP=0, reads occur on consecutive cycles.
  - On no match with count == POLL_MAX, respond with data = last read, err=1.
  - mask=0 always matches on the first read.
- RESP:
  - rsp_valid_o=1 with data/err held stable until rsp_ready_i=1. On that edge rsp_valid_o drops and the state returns to IDLE.
  - cmd_ready_o is asserted in the cycle after the handshake; there is no back-to-back command acceptance in the same cycle as a response.
  - No bus activity occurs while in RESP or IDLE.
- Commands are fully serialised: at most one outstanding, no queue.
- Reset mid-operation: an immediate abort to reset values. Any pending bus write (e.g. RMW between read and write) is never issued, and the pending response is discarded.
- Counters:
  - Poll count width is clog2(POLL_MAX+1); gap counter width is clog2(POLL_GAP+1), minimum 1.
  - Neither counter wraps; both clear on each command acceptance.

Test Plan:
- WRITE addr=1 data=0x3200 accepted at T -> T+1: acc_en=1, wr_en=1, addr=1, wdata=0x3200 for exactly one cycle; T+2: rsp_valid=1, data=0x3200, err=0.
- READ addr=4 with rdata_i=0x0155 -> T+1 access with wr_en=0, addr=4; rsp data=0x0155, err=0; wdata_o=0 throughout.
- RMW addr=2, mask=0x0030, data=0x0020, rdata_i=0x3135 -> read at T+1, write at T+2 with wdata=0x3125; rsp data=0x3125.
- POLL addr=6, mask=0x1000, data=0x0000; rdata_i=0x1000 for the first 3 reads then 0x0000 -> 4 reads spaced by POLL_GAP=3 idle cycles; rsp data=0x0000, err=0.
- POLL never matching, POLL_MAX=16 -> exactly 16 reads, then rsp err=1, data = last rdata_i; a following READ command works normally.
- rsp_ready_i held low 5 cycles after a READ -> rsp_valid/data stable, cmd_ready=0, no bus access. Separately, rstn_i pulsed low between RMW read and write -> no write cycle, all outputs 0, cmd_ready=1 after release.
